// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the pipeline stage registers.
// Holds default PCs, exception codes and the stage payload bundle.
package pipe_stage_skid_pkg;

  localparam int DATA_BITS = 32;
  localparam int PC_BITS   = 32;
  localparam int EXC_BITS  = 5;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;

  localparam logic [EXC_BITS-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_BITS-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_BITS-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_BITS-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_BITS-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_BITS-1:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [DATA_BITS-1:0] instr;
    logic [PC_BITS-1:0]   pc;
    logic [EXC_BITS-1:0]  exc;
    logic                 slot;
  } stage_pl_t;

endpackage

// File: rtl/pipe_stage_entry.sv
// One payload register (valid, instr, pc, exc, slot) with load and kill.
// Ports: kill_i/kill_pc_i redirect, ld_i/vld_i load, *_i data in, *_o state.
module pipe_stage_entry
  import pipe_stage_skid_pkg::*;
#(
  parameter int              DATA_W   = DATA_BITS,
  parameter int              PC_W     = PC_BITS,
  parameter int              EXC_W    = EXC_BITS,
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill_i,
  input  logic [PC_W-1:0]   kill_pc_i,
  input  logic              ld_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [EXC_W-1:0]  exc_i,
  input  logic              slot_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [EXC_W-1:0]  exc_o,
  output logic              slot_o
);

  logic              v_q, v_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [EXC_W-1:0]  exc_q, exc_d;
  logic              slot_q, slot_d;

  always_comb begin
    v_d     = v_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    slot_d  = slot_q;
    if (kill_i) begin
      v_d     = 1'b0;
      instr_d = '0;
      pc_d    = kill_pc_i;
      exc_d   = '0;
      slot_d  = 1'b0;
    end else if (ld_i) begin
      v_d = vld_i;
      if (vld_i) begin
        // a faulting instruction travels on as a nop
        instr_d = (exc_i != '0) ? '0 : instr_i;
        pc_d    = pc_i;
        exc_d   = exc_i;
        slot_d  = slot_i;
      end else begin
        // bubble keeps the last pc so it still names a fetch point
        instr_d = '0;
        exc_d   = '0;
        slot_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= 1'b0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
      exc_q   <= '0;
      slot_q  <= 1'b0;
    end else begin
      v_q     <= v_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
      slot_q  <= slot_d;
    end
  end

  assign valid_o = v_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign exc_o   = exc_q;
  assign slot_o  = slot_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional skid entry,
// req/flush redirect and a saturating stall counter.
// Ports: in_* upstream, out_* downstream, req/flush/flush_pc, stall_cnt.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int              DATA_W     = DATA_BITS,
  parameter int              PC_W       = PC_BITS,
  parameter int              EXC_W      = EXC_BITS,
  parameter logic [PC_W-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [PC_W-1:0] HANDLER_PC = DEF_HANDLER_PC,
  parameter int              SKID       = 1,
  parameter int              CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_slot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_slot,
  input  logic              req,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              kill;
  logic [PC_W-1:0]   kill_pc;
  logic              acc;
  logic              move;
  logic              main_v;
  logic              m_ld;
  logic              m_vld;
  logic [DATA_W-1:0] m_instr;
  logic [PC_W-1:0]   m_pc;
  logic [EXC_W-1:0]  m_exc;
  logic              m_slot;

  // req outranks flush for the redirect target
  assign kill    = req | flush;
  assign kill_pc = req ? HANDLER_PC : flush_pc;
  assign acc     = in_valid & in_ready & ~kill;
  assign move    = main_v & out_ready;
  assign m_ld    = move | ~main_v;

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_v;
      logic              skid_ld;
      logic              skid_vld;
      logic [DATA_W-1:0] skid_instr;
      logic [PC_W-1:0]   skid_pc;
      logic [EXC_W-1:0]  skid_exc;
      logic              skid_slot;
      logic              rdy_q, rdy_d;

      // skid fills only when main is stuck; it drains into main first
      assign skid_vld = acc & main_v & ~move;
      assign skid_ld  = skid_vld | (skid_v & move);

      assign m_vld   = skid_v | acc;
      assign m_instr = skid_v ? skid_instr : in_instr;
      assign m_pc    = skid_v ? skid_pc : in_pc;
      assign m_exc   = skid_v ? skid_exc : in_exc;
      assign m_slot  = skid_v ? skid_slot : in_slot;

      pipe_stage_entry #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .EXC_W   (EXC_W),
        .RESET_PC(RESET_PC)
      ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .kill_i   (kill),
        .kill_pc_i(kill_pc),
        .ld_i     (skid_ld),
        .vld_i    (skid_vld),
        .instr_i  (in_instr),
        .pc_i     (in_pc),
        .exc_i    (in_exc),
        .slot_i   (in_slot),
        .valid_o  (skid_v),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc),
        .exc_o    (skid_exc),
        .slot_o   (skid_slot)
      );

      // ready is the registered complement of the next skid occupancy
      always_comb begin
        rdy_d = ~skid_v;
        if (kill) begin
          rdy_d = 1'b1;
        end else if (skid_ld) begin
          rdy_d = ~skid_vld;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= rdy_d;
        end
      end

      assign in_ready = rdy_q;
    end else begin : g_flat
      assign in_ready = ~main_v | out_ready;
      assign m_vld    = acc;
      assign m_instr  = in_instr;
      assign m_pc     = in_pc;
      assign m_exc    = in_exc;
      assign m_slot   = in_slot;
    end
  endgenerate

  pipe_stage_entry #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .EXC_W   (EXC_W),
    .RESET_PC(RESET_PC)
  ) u_main (
    .clk      (clk),
    .rst      (rst),
    .kill_i   (kill),
    .kill_pc_i(kill_pc),
    .ld_i     (m_ld),
    .vld_i    (m_vld),
    .instr_i  (m_instr),
    .pc_i     (m_pc),
    .exc_i    (m_exc),
    .slot_i   (m_slot),
    .valid_o  (main_v),
    .instr_o  (out_instr),
    .pc_o     (out_pc),
    .exc_o    (out_exc),
    .slot_o   (out_slot)
  );

  assign out_valid = main_v;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (main_v && !out_ready && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid (skid, flat and 4-bit counter).
// Scoreboard of expected entries against entries seen leaving the stage.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  in_exc;
  logic        in_slot;
  logic        out_ready;
  logic        req;
  logic        flush;
  logic [31:0] flush_pc;

  logic        in_ready, out_valid, out_slot;
  logic [31:0] out_instr, out_pc;
  logic [4:0]  out_exc;
  logic [15:0] stall_cnt;

  logic        in_ready_0, out_valid_0, out_slot_0;
  logic [31:0] out_instr_0, out_pc_0;
  logic [4:0]  out_exc_0;
  logic [15:0] stall_cnt_0;

  logic        in_ready_4, out_valid_4, out_slot_4;
  logic [31:0] out_instr_4, out_pc_4;
  logic [4:0]  out_exc_4;
  logic [3:0]  stall_cnt_4;

  pipe_stage_skid #(.SKID(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_exc(in_exc), .in_slot(in_slot),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_exc(out_exc), .out_slot(out_slot),
    .req(req), .flush(flush), .flush_pc(flush_pc),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.SKID(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_0),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_exc(in_exc), .in_slot(in_slot),
    .out_valid(out_valid_0), .out_ready(out_ready),
    .out_instr(out_instr_0), .out_pc(out_pc_0),
    .out_exc(out_exc_0), .out_slot(out_slot_0),
    .req(req), .flush(flush), .flush_pc(flush_pc),
    .stall_cnt(stall_cnt_0)
  );

  pipe_stage_skid #(.SKID(1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_4),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_exc(in_exc), .in_slot(in_slot),
    .out_valid(out_valid_4), .out_ready(out_ready),
    .out_instr(out_instr_4), .out_pc(out_pc_4),
    .out_exc(out_exc_4), .out_slot(out_slot_4),
    .req(req), .flush(flush), .flush_pc(flush_pc),
    .stall_cnt(stall_cnt_4)
  );

  int total = 0;
  int bad = 0;

  stage_pl_t exp_q[$];
  stage_pl_t obs_q[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !req && !flush)
      obs_q.push_back(stage_pl_t'{instr: out_instr, pc: out_pc,
                                  exc: out_exc, slot: out_slot});
  end

  function automatic stage_pl_t mk(input logic [31:0] i,
                                   input logic [31:0] p,
                                   input logic [4:0] e,
                                   input logic s);
    stage_pl_t r;
    r.instr = (e != 5'd0) ? 32'd0 : i;
    r.pc    = p;
    r.exc   = e;
    r.slot  = s;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_instr = '0;
    in_pc    = '0;
    in_exc   = '0;
    in_slot  = 1'b0;
    req      = 1'b0;
    flush    = 1'b0;
    flush_pc = '0;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [4:0] e, input logic s);
    in_valid = 1'b1;
    in_instr = i;
    in_pc    = p;
    in_exc   = e;
    in_slot  = s;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    out_ready = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%0b want=0", out_valid);
    end
    total++;
    if (out_pc !== 32'h3000) begin
      bad++; $display("FAIL rst_pc got=%h want=00003000", out_pc);
    end
    total++;
    if (out_instr !== 32'd0 || out_exc !== 5'd0 || out_slot !== 1'b0) begin
      bad++;
      $display("FAIL rst_payload got=%h/%0d/%0b want=0/0/0",
               out_instr, out_exc, out_slot);
    end
    total++;
    if (stall_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d want=0", stall_cnt);
    end
    total++;
    if (in_ready !== 1'b1 || in_ready_0 !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%0b/%0b want=1/1", in_ready, in_ready_0);
    end
  endtask

  task automatic test_stream();
    int base;
    logic [31:0] p;
    base = obs_q.size();
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p = 32'h3000 + 32'(4 * i);
      send(32'h2401_0000 + 32'(i), p, 5'd0, 1'b0);
      exp_q.push_back(mk(32'h2401_0000 + 32'(i), p, 5'd0, 1'b0));
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL stream_ready[%0d] got=%0b want=1", i, in_ready);
      end
      tick(1);
      total++;
      if (out_valid !== 1'b1 || out_pc !== p) begin
        bad++;
        $display("FAIL stream_out[%0d] got=%0b/%h want=1/%h",
                 i, out_valid, out_pc, p);
      end
    end
    idle();
    tick(1);
    total++;
    if (out_valid !== 1'b0 || out_pc !== 32'h3008 || out_instr !== 32'd0) begin
      bad++;
      $display("FAIL stream_bubble got=%0b/%h/%h want=0/00003008/0",
               out_valid, out_pc, out_instr);
    end
    total++;
    if (obs_q.size() - base != exp_q.size()) begin
      bad++;
      $display("FAIL stream_count got=%0d want=%0d",
               obs_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs_q[base+i] !== exp_q[i]) begin
          bad++;
          $display("FAIL stream_sb[%0d] got=%h want=%h",
                   i, obs_q[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    do_reset();
    base = obs_q.size();
    exp_q.delete();
    out_ready = 1'b0;
    send(32'hAAAA_0001, 32'h3100, 5'd0, 1'b0);
    exp_q.push_back(mk(32'hAAAA_0001, 32'h3100, 5'd0, 1'b0));
    tick(1);
    send(32'hAAAA_0002, 32'h3104, 5'd0, 1'b1);
    exp_q.push_back(mk(32'hAAAA_0002, 32'h3104, 5'd0, 1'b1));
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_ready_b got=%0b want=1", in_ready);
    end
    tick(1);
    total++;
    if (in_ready !== 1'b0 || out_pc !== 32'h3100 || stall_cnt !== 16'd1) begin
      bad++;
      $display("FAIL bp_full got=%0b/%h/%0d want=0/00003100/1",
               in_ready, out_pc, stall_cnt);
    end
    send(32'hAAAA_0003, 32'h3108, 5'd0, 1'b0);
    tick(2);
    total++;
    if (in_ready !== 1'b0 || out_pc !== 32'h3100 || stall_cnt !== 16'd3) begin
      bad++;
      $display("FAIL bp_hold got=%0b/%h/%0d want=0/00003100/3",
               in_ready, out_pc, stall_cnt);
    end
    idle();
    out_ready = 1'b1;
    tick(1);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h3104 || in_ready !== 1'b1 ||
        stall_cnt !== 16'd3) begin
      bad++;
      $display("FAIL bp_drain got=%0b/%h/%0b/%0d want=1/00003104/1/3",
               out_valid, out_pc, in_ready, stall_cnt);
    end
    tick(1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_empty got=%0b want=0", out_valid);
    end
    total++;
    if (obs_q.size() - base != exp_q.size()) begin
      bad++;
      $display("FAIL bp_count got=%0d want=%0d",
               obs_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs_q[base+i] !== exp_q[i]) begin
          bad++;
          $display("FAIL bp_sb[%0d] got=%h want=%h",
                   i, obs_q[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_exc();
    int base;
    base = obs_q.size();
    exp_q.delete();
    out_ready = 1'b1;
    send(32'h8C01_0000, 32'h3010, 5'd4, 1'b1);
    exp_q.push_back(mk(32'h8C01_0000, 32'h3010, 5'd4, 1'b1));
    tick(1);
    total++;
    if (out_valid !== 1'b1 || out_instr !== 32'd0) begin
      bad++;
      $display("FAIL exc_nop got=%0b/%h want=1/0", out_valid, out_instr);
    end
    total++;
    if (out_exc !== 5'd4 || out_pc !== 32'h3010 || out_slot !== 1'b1) begin
      bad++;
      $display("FAIL exc_fields got=%0d/%h/%0b want=4/00003010/1",
               out_exc, out_pc, out_slot);
    end
    idle();
    tick(1);
    total++;
    if (out_valid !== 1'b0 || out_exc !== 5'd0) begin
      bad++;
      $display("FAIL exc_bubble got=%0b/%0d want=0/0", out_valid, out_exc);
    end
    total++;
    if (obs_q.size() - base != exp_q.size()) begin
      bad++;
      $display("FAIL exc_count got=%0d want=%0d",
               obs_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs_q[base+i] !== exp_q[i]) begin
          bad++;
          $display("FAIL exc_sb[%0d] got=%h want=%h",
                   i, obs_q[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_redirect();
    int base;
    do_reset();
    base = obs_q.size();
    out_ready = 1'b0;
    send(32'hBBBB_0001, 32'h3020, 5'd0, 1'b0);
    tick(1);
    send(32'hBBBB_0002, 32'h3024, 5'd0, 1'b0);
    tick(1);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rd_full got=%0b/%0b want=0/1", in_ready, out_valid);
    end
    send(32'hBBBB_0003, 32'h3028, 5'd0, 1'b0);
    flush = 1'b1;
    flush_pc = 32'h3040;
    tick(1);
    idle();
    total++;
    if (out_valid !== 1'b0 || out_pc !== 32'h3040 || out_instr !== 32'd0 ||
        out_exc !== 5'd0) begin
      bad++;
      $display("FAIL rd_flush got=%0b/%h/%h/%0d want=0/00003040/0/0",
               out_valid, out_pc, out_instr, out_exc);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rd_skid_empty got=%0b want=1", in_ready);
    end
    out_ready = 1'b1;
    tick(2);
    total++;
    if (out_valid !== 1'b0 || out_pc !== 32'h3040) begin
      bad++;
      $display("FAIL rd_no_leak got=%0b/%h want=0/00003040",
               out_valid, out_pc);
    end
    out_ready = 1'b0;
    send(32'hBBBB_0004, 32'h3200, 5'd0, 1'b0);
    tick(1);
    send(32'hBBBB_0005, 32'h3204, 5'd0, 1'b0);
    req = 1'b1;
    flush = 1'b1;
    flush_pc = 32'h3080;
    tick(1);
    idle();
    total++;
    if (out_valid !== 1'b0 || out_pc !== 32'h4180 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd_req got=%0b/%h/%0b want=0/00004180/1",
               out_valid, out_pc, in_ready);
    end
    tick(1);
    total++;
    if (out_valid !== 1'b0 || out_pc !== 32'h4180) begin
      bad++;
      $display("FAIL rd_discard got=%0b/%h want=0/00004180",
               out_valid, out_pc);
    end
    total++;
    if (obs_q.size() != base) begin
      bad++;
      $display("FAIL rd_sb got=%0d want=0", obs_q.size() - base);
    end
  endtask

  task automatic test_skid0();
    do_reset();
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h3300, 5'd0, 1'b0);
    #1;
    total++;
    if (in_ready_0 !== 1'b1) begin
      bad++; $display("FAIL s0_ready_empty got=%0b want=1", in_ready_0);
    end
    tick(1);
    total++;
    if (out_valid_0 !== 1'b1 || out_pc_0 !== 32'h3300 || in_ready_0 !== 1'b0) begin
      bad++;
      $display("FAIL s0_stall got=%0b/%h/%0b want=1/00003300/0",
               out_valid_0, out_pc_0, in_ready_0);
    end
    idle();
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready_0 !== 1'b1 || out_pc_0 !== 32'h3300) begin
      bad++;
      $display("FAIL s0_comb got=%0b/%h want=1/00003300",
               in_ready_0, out_pc_0);
    end
    tick(1);
    total++;
    if (out_valid_0 !== 1'b0 || out_pc_0 !== 32'h3300) begin
      bad++;
      $display("FAIL s0_drain got=%0b/%h want=0/00003300",
               out_valid_0, out_pc_0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    send(32'hCCCC_0001, 32'h3400, 5'd0, 1'b0);
    tick(1);
    idle();
    tick(20);
    total++;
    if (stall_cnt_4 !== 4'd15) begin
      bad++; $display("FAIL sat_cnt4 got=%0d want=15", stall_cnt_4);
    end
    total++;
    if (stall_cnt !== 16'd20) begin
      bad++; $display("FAIL sat_cnt16 got=%0d want=20", stall_cnt);
    end
    req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(3);
    total++;
    if (stall_cnt !== 16'd21 || stall_cnt_4 !== 4'd15 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sat_req got=%0d/%0d/%0b want=21/15/0",
               stall_cnt, stall_cnt_4, out_valid);
    end
  endtask

  initial begin
    idle();
    out_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_exc();
    test_redirect();
    test_skid0();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register, the generalised successor of the fixed IF/ID latch, carrying instr, pc, exception code and delay-slot flag.
- Replaces the stall/pass scheme with a valid/ready handshake.
- Optional 2-entry skid buffer so in_ready is a registered signal.
- Supports exception-request redirect to the handler PC, and flush redirect to an arbitrary PC.
- Saturating stall-cycle performance counter.
- Intended for every inter-stage boundary (F/D, D/E, E/M).

Parameters:
DATA_W, 32, instruction/payload width
PC_W, 32, PC width
EXC_W, 5, exception-code width (0 = no exception)
RESET_PC, 32'h0000_3000, out_pc value after reset
HANDLER_PC, 32'h0000_4180, out_pc value after req
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept this cycle
in_instr  in  DATA_W  instruction
in_pc  in  PC_W  PC of instruction
in_exc  in  EXC_W  exception code raised upstream
in_slot  in  1  instruction is in a delay slot
out_valid  out  1  output entry valid
out_ready  in  1  downstream consumes entry this cycle
out_instr  out  DATA_W  instruction (0 when invalid or when out_exc != 0)
out_pc  out  PC_W  PC of output entry, or redirect target when bubble
out_exc  out  EXC_W  exception code
out_slot  out  1  delay-slot flag
req  in  1  exception/interrupt taken: kill and redirect to HANDLER_PC
flush  in  1  branch/replay flush: kill and redirect to flush_pc
flush_pc  in  PC_W  flush target
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready

Behaviour:
- Priority per clock edge: rst > req > flush > normal handshake.
- Reset values:
  - out_valid=0, skid empty, out_instr=0, out_pc=RESET_PC, out_exc=0, out_slot=0, stall_cnt=0.
  - in_ready=1 in the first cycle after reset.
- req:
  - Main and skid entries invalidated; out_valid=0.
  - out_pc=HANDLER_PC, out_exc=0, out_slot=0, out_instr=0.
  - Input presented in the same cycle is discarded.
- flush:
  - Same as req, but out_pc=flush_pc.
  - req and flush together: req wins, out_pc=HANDLER_PC.
- Accept: in_valid && in_ready && !req && !flush.
- Capture rule: if in_exc != 0, the stored instr is forced to 0 (nop); pc, exc and slot are kept as given.
- Output move: out_valid && out_ready.
- SKID=1:
  - in_ready is a register and equals !skid_valid.
  - Accept with main empty or moving: entry goes to main, latency 1 cycle.
  - Accept with main full and not moving: entry goes to skid; in_ready drops the next cycle.
  - Main moving with skid full: skid moves to main, skid empties, in_ready returns to 1 the next cycle.
  - No entry is ever lost or duplicated; order is preserved.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - Skid storage absent.
- Bubble state (out_valid=0):
  - out_instr=0, out_exc=0.
  - out_pc holds the last redirect target or the last moved-out pc.
- stall_cnt:
  - +1 each cycle with out_valid && !out_ready, saturating at all-ones.
  - Cleared only by rst; req and flush do not clear it.
- out_* change only on clock edges.
- Reset mid-transfer discards all entries.

Decomposition:
- Shared package:
  - RESET_PC and HANDLER_PC constants.
  - EXC_W and exception-code constants (EXC_NONE=0).
  - A stage-payload struct {instr, pc, exc, slot} shared with the other stage instances.
- One sub-module, pipe_stage_entry: a payload register with load enable and a kill/redirect input. Instantiated twice (main, skid) when SKID=1.

Test Plan:
- Reset: rst=1 for 2 cycles -> out_valid=0, out_pc=32'h3000, out_instr=0, stall_cnt=0, in_ready=1.
- Streaming: SKID=1, out_ready=1, three entries pc=0x3000/3004/3008 on consecutive cycles -> each appears on out one cycle later, in order, with in_ready constantly 1.
- Backpressure: out_ready=0 while two entries are sent -> second entry held in skid, in_ready=0.
  - Then out_ready=1 -> entries exit in order, in_ready=1 again.
  - stall_cnt equals the number of stalled cycles.
- Exception capture: in_exc=5'd4, in_instr=0x8C010000 -> out_instr=0, out_exc=4, out_pc preserved.
- Redirect: flush with flush_pc=0x3040 while main and skid are full -> next cycle out_valid=0, out_pc=0x3040, skid empty.
  - req and flush together -> out_pc=0x4180.
- SKID=0 variant: with out_ready=0 and out_valid=1, in_ready=0 in the same cycle.
  - Raising out_ready -> in_ready=1 combinationally in that cycle.
- Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15.
